costable_arbiter: RTL
=====================

# costable_arbiter

Two-port round-robin arbiter that shares the single `cosTable` instance (1024-entry, 16-bit signed, one-cycle registered read) between two requesters. Typical requesters are the carrier NCO and a second NCO, such as the modulation tone or quadrature path. Each requester uses a req/gnt handshake and gets its own registered data output with a valid strobe. The block sits between the phase accumulators and `cosTable`; its outputs feed the PWM offset and scale stage.

## Interface
Parameters:
- ADDR_W, 10, cosTable address width.
- DATA_W, 16, cosTable data width, signed two's complement.
- ROM_LAT, 1, cosTable read latency in cycles (address edge to data valid). Legal values are 1..3.

Ports:
- clk  in  1  system clock, 25 MHz PLL output.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 read request.
- addr0  in  ADDR_W  requester 0 address; must be stable while req0 is high and gnt0 is low.
- gnt0  out  1  requester 0 granted this cycle (combinational).
- valid0  out  1  one-cycle strobe; data0 holds a new sample.
- data0  out  DATA_W  requester 0 read data (registered).
- req1, addr1, gnt1, valid1, data1: same as above for requester 1.
- rom_addr  out  ADDR_W  address to cosTable (combinational mux).
- rom_data  in  DATA_W  data from cosTable.

## Operation
- **Grants per cycle:** at most one grant per cycle. `gnt0 & gnt1` is never 1.
- **Transaction:** each cycle with `reqX & gntX` is exactly one read transaction. A requester may hold reqX high for back-to-back reads, changing addrX after each grant.
- **Arbitration:**
  - A single requester is granted immediately.
  - If both request, grant the requester that is not `last`. `last` is a 1-bit register updated to the granted index on every grant.
- **Reset:** sets `last` to 1, so requester 0 wins the first tie.
- **rom_addr:**
  - On a grant, rom_addr = addr of the granted requester.
  - With no grant, rom_addr holds the last granted address (held register, reset 0) to minimise ROM toggling.
- **Tag pipeline:** a ROM_LAT-deep shift register carries {valid, id} per transaction. When the tag emerges, rom_data is registered into data[id] and valid[id] pulses for one cycle.
- **Data hold:** dataX holds its value until the next valid for that requester.
- **Reset state:** while rst is high:
  - gnt0 = gnt1 = 0, even with requests present.
  - valid0 = valid1 = 0; data0 = data1 = 0.
  - Tag pipeline cleared; rom_addr = 0.
- **Reset mid-operation:** in-flight transactions are discarded, with no valid after reset releases. Requesters must re-request.
- **Width rules:** data passes through unmodified, sign preserved. No offsetting here; the +32768 PWM offset stays downstream.

## Timing
- Request sampled and granted in the same cycle N; gnt is combinational from req, `last` and rst.
- cosTable captures rom_addr at the end of N.
- rom_data is valid in cycle N+ROM_LAT and is captured into dataX at the end of that cycle.
- validX is high in cycle N+ROM_LAT+1. Total latency from req to valid is ROM_LAT+1 cycles (2 at default).
- Throughput is one read per cycle aggregate. With both requesters continuously requesting, grants alternate 0,1,0,1 and each gets one sample every 2 cycles.
- Valid strobes for different ids never coincide. Valids appear in grant order.
- Requirement on requesters: no combinational path from gntX back to reqX.
- After rst deasserts at cycle R, the first grant is possible in cycle R+1, meaning the first cycle with rst low.

## Test plan
- **Reset:**
  - Stimulus: hold rst for 3 cycles with req0 = req1 = 1.
  - Required: gnt0 = gnt1 = 0, valid0 = valid1 = 0, data0 = data1 = 0 and rom_addr = 0 throughout.
  - Required: first cycle after release grants req0.
- **Single read:**
  - Stimulus: req0 for 1 cycle, addr0 = 0.
  - Required: gnt0 in the same cycle; valid0 2 cycles later; data0 = cosTable[0] = 0x7FFF (full-scale positive); data0 holds afterwards.
- **Contention:**
  - Stimulus: req0 = req1 = 1 continuously for 8 cycles, addr0 = 0, addr1 = 512.
  - Required: grants alternate 0,1,0,1…, 4 each.
  - Required: valid0/valid1 alternate 2 cycles behind; data1 = cosTable[512] (≈0x8001, negative full-scale); valids never overlap.
- **Single-requester streaming:**
  - Stimulus: req1 held, addr1 incrementing 1020..1023 then wrapping to 0..3.
  - Required: gnt1 every cycle; 8 consecutive valid1 pulses; data matches the ROM at each address, including the wrap.
- **Reset mid-flight:**
  - Stimulus: grant req0 at cycle N, assert rst in cycle N+1.
  - Required: no valid0 appears; data0 = 0; after release `last` = 1 and tie goes to req0.
- **Idle address hold:**
  - Stimulus: grant req1 with addr1 = 0x155, then no requests for 5 cycles.
  - Required: rom_addr stays 0x155; no valid strobes beyond the single expected one.

Source files
------------

// File: rtl/costable_arbiter.sv
// Round-robin arbiter sharing one registered-read cosine ROM between two requesters.
// A tag pipeline matches the ROM latency and routes each returning sample to its requester.
module costable_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 16,
  parameter int ROM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  output logic              gnt0_o,
  output logic              valid0_o,
  output logic [DATA_W-1:0] data0_o,
  input  logic              req1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  output logic              gnt1_o,
  output logic              valid1_o,
  output logic [DATA_W-1:0] data1_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i
);

  logic              last_q;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ROM_LAT-1:0] tag_v_q, tag_v_d;
  logic [ROM_LAT-1:0] tag_id_q, tag_id_d;
  logic              valid0_q, valid1_q;
  logic [DATA_W-1:0] data0_q, data1_q;
  logic              gnt0, gnt1;
  logic              out_v, out_id;

  // On a tie the requester that was not served last wins.
  assign gnt0 = ~rst_i & req0_i & (~req1_i | last_q);
  assign gnt1 = ~rst_i & req1_i & (~req0_i | ~last_q);

  always_comb begin
    rom_addr_d = rom_addr_q;
    if (gnt0)      rom_addr_d = addr0_i;
    else if (gnt1) rom_addr_d = addr1_i;
  end

  always_comb begin
    tag_v_d     = tag_v_q;
    tag_id_d    = tag_id_q;
    tag_v_d[0]  = gnt0 | gnt1;
    tag_id_d[0] = gnt1;
    for (int i = 1; i < ROM_LAT; i++) begin
      tag_v_d[i]  = tag_v_q[i-1];
      tag_id_d[i] = tag_id_q[i-1];
    end
  end

  assign out_v  = tag_v_q[ROM_LAT-1];
  assign out_id = tag_id_q[ROM_LAT-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q     <= 1'b1;
      rom_addr_q <= '0;
      tag_v_q    <= '0;
      tag_id_q   <= '0;
      valid0_q   <= 1'b0;
      valid1_q   <= 1'b0;
      data0_q    <= '0;
      data1_q    <= '0;
    end else begin
      if (gnt0 | gnt1) last_q <= gnt1;
      rom_addr_q <= rom_addr_d;
      tag_v_q    <= tag_v_d;
      tag_id_q   <= tag_id_d;
      valid0_q   <= out_v & ~out_id;
      valid1_q   <= out_v & out_id;
      if (out_v & ~out_id) data0_q <= rom_data_i;
      if (out_v & out_id)  data1_q <= rom_data_i;
    end
  end

  // Outputs read as idle/zero for every cycle that reset is asserted.
  assign gnt0_o     = gnt0;
  assign gnt1_o     = gnt1;
  assign rom_addr_o = rst_i ? '0 : rom_addr_d;
  assign valid0_o   = valid0_q & ~rst_i;
  assign valid1_o   = valid1_q & ~rst_i;
  assign data0_o    = rst_i ? '0 : data0_q;
  assign data1_o    = rst_i ? '0 : data1_q;

endmodule
